// File: rtl/pattern_scan_arbiter_if.sv
// pattern_scan_arbiter_if: per-requester request/bit-stream lanes and the one-hot grant back
interface pattern_scan_arbiter_if #(parameter int N = 4);
  logic [N-1:0] req, bit_in, bit_valid, bit_last, gnt;
  modport master (output req, bit_in, bit_valid, bit_last, input gnt);
  modport slave (input req, bit_in, bit_valid, bit_last, output gnt);
endinterface

// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter: round-robin shared serial pattern detector reporting found/position/timeout
module pattern_scan_arbiter #(
  parameter int N = 4,
  parameter int W = 4,
  parameter int CW = 8,
  parameter int TMO = 16
) (
  input  logic clk,
  input  logic reset,
  pattern_scan_arbiter_if.slave bus,
  input  logic [W-1:0] pattern,
  output logic busy,
  output logic done,
  output logic found,
  output logic timeout,
  output logic [CW-1:0] match_pos
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [CW:0] WL = (CW+1)'(W);
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
  state_t state, state_n;
  logic [N-1:0] gnt_n;
  logic [IW-1:0] owner, owner_n, last_w, last_n, pick;
  logic [W-1:0] pat, pat_n, sr, sr_n, sr_shift;
  logic [CW-1:0] cnt, cnt_n, pos_n;
  logic [TW-1:0] tmr, tmr_n;
  logic found_n, timeout_n, pick_ok, hit;
  assign busy = state != IDLE;
  assign done = state == REPORT;
  assign sr_shift = {sr[W-2:0], bus.bit_in[owner]};
  assign hit = ({1'b0, cnt} + 1'b1 >= WL) && sr_shift == pat;
  // scan downward so the nearest requester after last_w wins
  always_comb begin
    pick = last_w;
    pick_ok = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (bus.req[IW'((int'(last_w) + i) % N)]) begin
        pick = IW'((int'(last_w) + i) % N);
        pick_ok = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    gnt_n = bus.gnt;
    owner_n = owner;
    last_n = last_w;
    pat_n = pat;
    sr_n = sr;
    cnt_n = cnt;
    tmr_n = tmr;
    found_n = found;
    timeout_n = timeout;
    pos_n = match_pos;
    case (state)
      IDLE: if (pick_ok) begin
        state_n = SCAN;
        gnt_n = N'(1) << pick;
        owner_n = pick;
        last_n = pick;
        pat_n = pattern;
        sr_n = '0;
        cnt_n = '0;
        tmr_n = '0;
        found_n = 1'b0;
        timeout_n = 1'b0;
        pos_n = '0;
      end
      SCAN: if (!bus.req[owner]) begin
        state_n = IDLE;
        gnt_n = '0;
      end else if (bus.bit_valid[owner]) begin
        sr_n = sr_shift;
        cnt_n = &cnt ? cnt : cnt + 1'b1;
        tmr_n = '0;
        if (hit) begin
          found_n = 1'b1;
          pos_n = cnt;
          state_n = REPORT;
        end else if (bus.bit_last[owner]) state_n = REPORT;
      end else begin
        tmr_n = tmr + 1'b1;
        if (tmr_n == TW'(TMO)) begin
          timeout_n = 1'b1;
          state_n = REPORT;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      bus.gnt <= '0;
      owner <= '0;
      last_w <= IW'(N - 1);
      pat <= '0;
      sr <= '0;
      cnt <= '0;
      tmr <= '0;
      found <= 1'b0;
      timeout <= 1'b0;
      match_pos <= '0;
    end else begin
      state <= state_n;
      bus.gnt <= gnt_n;
      owner <= owner_n;
      last_w <= last_n;
      pat <= pat_n;
      sr <= sr_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      found <= found_n;
      timeout <= timeout_n;
      match_pos <= pos_n;
    end
  end
endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb_pattern_scan_arbiter: directed scans checked against a bit-history model every cycle
module tb_pattern_scan_arbiter;
  localparam int N = 4, W = 4, CW = 8, TMO = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic [W-1:0] pattern = 4'b1010;
  logic busy, done, found, timeout;
  logic [CW-1:0] match_pos;
  int checks = 0, errors = 0, cyc = 0;
  pattern_scan_arbiter_if #(.N(N)) bus();
  pattern_scan_arbiter #(.N(N), .W(W), .CW(CW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pattern(pattern), .busy(busy),
    .done(done), .found(found), .timeout(timeout), .match_pos(match_pos));
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: 0 idle, 1 scanning, 2 reporting; result derived from the full bit history
  int m_state = 0, m_owner = 0, m_last = N - 1, m_idle = 0, m_pos = 0;
  logic [N-1:0] m_gnt = '0;
  logic [W-1:0] m_pat = '0;
  bit m_found = 0, m_tmo = 0;
  bit hist[$];
  function automatic bit ends_with_pattern();
    if (hist.size() < W) return 0;
    for (int k = 0; k < W; k++)
      if (hist[hist.size() - W + k] != m_pat[W-1-k]) return 0;
    return 1;
  endfunction
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_state = 0; m_gnt = '0; m_last = N - 1; m_found = 0; m_tmo = 0; m_pos = 0; m_idle = 0;
      hist.delete();
    end else if (m_state == 2) begin
      m_state = 0; m_gnt = '0;
    end else if (m_state == 0) begin
      for (int i = 1; i <= N; i++)
        if (m_state == 0 && bus.req[(m_last + i) % N]) begin
          m_owner = (m_last + i) % N; m_state = 1;
        end
      if (m_state == 1) begin
        m_last = m_owner; m_gnt = '0; m_gnt[m_owner] = 1'b1; m_pat = pattern;
        hist.delete(); m_idle = 0; m_found = 0; m_tmo = 0; m_pos = 0;
      end
    end else if (!bus.req[m_owner]) begin
      m_state = 0; m_gnt = '0;
    end else if (bus.bit_valid[m_owner]) begin
      hist.push_back(bus.bit_in[m_owner]);
      m_idle = 0;
      if (ends_with_pattern()) begin
        m_found = 1;
        m_pos = hist.size() - 1 > (1 << CW) - 1 ? (1 << CW) - 1 : hist.size() - 1;
        m_state = 2;
      end else if (bus.bit_last[m_owner]) m_state = 2;
    end else begin
      m_idle++;
      if (m_idle == TMO) begin m_tmo = 1; m_state = 2; end
    end
  end
  always @(negedge clk) if (reset) begin
    chk("gnt", bus.gnt, m_gnt);
    chk("busy", busy, m_state != 0);
    chk("done", done, m_state == 2);
    chk("found", found, m_found);
    chk("timeout", timeout, m_tmo);
    chk("match_pos", match_pos, m_pos[CW-1:0]);
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic send(int r, bit b, bit l);
    bus.bit_in[r] = b; bus.bit_valid[r] = 1'b1; bus.bit_last[r] = l;
    step();
    bus.bit_valid[r] = 1'b0; bus.bit_last[r] = 1'b0;
  endtask
  task automatic send_seq(int r, logic [15:0] bits, int len, bit last_on_end);
    for (int i = len - 1; i >= 0; i--) send(r, bits[i], last_on_end && i == 0);
  endtask
  task automatic wait_done(int budget, output int n);
    n = 0;
    while (!done && n < budget) begin step(); n++; end
    chk("done_within_budget", done, 1);
  endtask
  task automatic result(string nm, bit f, bit t, int p);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_found"}, found, f);
    chk({nm, "_timeout"}, timeout, t);
    chk({nm, "_pos"}, match_pos, p);
  endtask
  initial begin
    bus.req = '0; bus.bit_in = '0; bus.bit_valid = '0; bus.bit_last = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", bus.gnt, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_found", found, 0); chk("rst_timeout", timeout, 0); chk("rst_pos", match_pos, 0);
    reset = 1'b1;
    step();
    bus.req[0] = 1'b1; step();
    chk("t1_gnt", bus.gnt, 4'b0001);
    send_seq(0, 16'b11010, 5, 0);
    result("t1", 1, 0, 4);
    bus.req[0] = 1'b0; step();
    bus.req[0] = 1'b1; step();
    chk("t2a_gnt", bus.gnt, 4'b0001);
    send_seq(0, 16'b1010, 4, 1);
    result("t2a", 1, 0, 3);
    bus.req[0] = 1'b0; step();
    bus.req[0] = 1'b1; step();
    send_seq(0, 16'b1011010, 7, 0);
    result("t2b", 1, 0, 6);
    bus.req[0] = 1'b0; step();
    bus.req[2] = 1'b1; step();
    chk("t4_gnt", bus.gnt, 4'b0100);
    bus.bit_in[3] = 1'b1; bus.bit_valid[3] = 1'b1; bus.bit_last[3] = 1'b1;
    send_seq(2, 16'b111, 3, 1);
    result("t4", 0, 0, 0);
    bus.bit_valid[3] = 1'b0; bus.bit_last[3] = 1'b0;
    bus.req[2] = 1'b0; step();
    bus.req[1] = 1'b1; step();
    chk("t5_gnt", bus.gnt, 4'b0010);
    send(1, 1, 0);
    wait_done(30, cyc);
    chk("t5_idle_cycles", cyc, 16);
    result("t5", 0, 1, 0);
    bus.req[1] = 1'b0; step();
    bus.req[3] = 1'b1; step();
    chk("sat_gnt", bus.gnt, 4'b1000);
    for (int i = 0; i < 300; i++) send(3, 0, 0);
    send_seq(3, 16'b1010, 4, 0);
    result("sat", 1, 0, 255);
    bus.req[3] = 1'b0; step();
    reset = 1'b0; step(); reset = 1'b1;
    bus.req = 4'b0101; step();
    chk("t3_gnt1", bus.gnt, 4'b0001);
    send(0, 0, 1); step(); step();
    chk("t3_gnt2", bus.gnt, 4'b0100);
    send(2, 0, 1); step(); step();
    chk("t3_gnt3", bus.gnt, 4'b0001);
    send(0, 0, 1);
    bus.req = '0; step(); step();
    bus.req[1] = 1'b1; step();
    chk("t6_gnt", bus.gnt, 4'b0010);
    send(1, 1, 0);
    bus.req[1] = 1'b0; step();
    chk("t6_abort_gnt", bus.gnt, 0);
    chk("t6_abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin chk("t6_no_done", done, 0); step(); end
    chk("t6_abort_found", found, 0);
    bus.req = 4'b0010; step();
    chk("t6_regnt", bus.gnt, 4'b0010);
    send(1, 1, 0);
    reset = 1'b0;
    #1;
    chk("t6_rst_gnt", bus.gnt, 0); chk("t6_rst_busy", busy, 0); chk("t6_rst_done", done, 0);
    chk("t6_rst_found", found, 0); chk("t6_rst_pos", match_pos, 0);
    bus.req = 4'b1001; step();
    reset = 1'b1; step();
    chk("t6_post_rst_gnt", bus.gnt, 4'b0001);
    bus.req = '0; step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
